// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with a 2-entry valid/ready skid buffer.
// Decode happens before the output register; in_ready is a flop.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic             err;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic        isI, isS, isB, isU, isJ, isZ;
  logic        illegal;
  logic [31:0] imm32;
  logic [XLEN-1:0] immX;
  logic        unusedOpcode;

  entry_t newE, outQ, skidQ, outD, skidD;
  logic   outValidQ, skidValidQ, inReadyQ;
  logic   outValidD, skidValidD;
  logic   inXfer, outXfer;

  assign unusedOpcode = ^in_instr[6:0];

  always_comb begin
    isI = (in_immsrc == 3'b000);
    isS = (in_immsrc == 3'b001);
    isB = (in_immsrc == 3'b010);
    isU = (in_immsrc == 3'b011);
    isJ = (in_immsrc == 3'b100);
    isZ = (in_immsrc == 3'b101);
    imm32   = '0;
    illegal = 1'b0;
    unique case (1'b1)
      isI: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      isS: imm32 = {{20{in_instr[31]}}, in_instr[31:25],
                    in_instr[11:7]};
      isB: imm32 = {{19{in_instr[31]}}, in_instr[31],
                    in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
      isU: imm32 = {in_instr[31:12], 12'b0};
      isJ: imm32 = {{11{in_instr[31]}}, in_instr[31],
                    in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};
      isZ: imm32 = {27'b0, in_instr[19:15]};
      default: illegal = 1'b1;
    endcase
  end

  // Z is already zero in bit 31, so one sign fill covers every format
  if (XLEN > 32) begin : gWide
    assign immX = {{(XLEN-32){imm32[31]}}, imm32};
  end else begin : gNarrow
    assign immX = imm32;
  end

  assign newE = '{imm: immX, err: illegal, tag: in_tag};

  assign inXfer  = in_valid & inReadyQ;
  assign outXfer = outValidQ & out_ready;

  always_comb begin
    outD       = outQ;
    skidD      = skidQ;
    outValidD  = outValidQ;
    skidValidD = skidValidQ;
    if (outXfer || !outValidQ) begin
      if (skidValidQ) begin
        outD       = skidQ;
        outValidD  = 1'b1;
        skidValidD = 1'b0;
      end else if (inXfer) begin
        outD      = newE;
        outValidD = 1'b1;
      end else begin
        outValidD = 1'b0;
      end
    end else if (inXfer) begin
      skidD      = newE;
      skidValidD = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValidQ  <= 1'b0;
      skidValidQ <= 1'b0;
      inReadyQ   <= 1'b0;
      outQ       <= '0;
      skidQ      <= '0;
    end else if (flush) begin
      outValidQ  <= 1'b0;
      skidValidQ <= 1'b0;
      inReadyQ   <= 1'b1;
    end else begin
      outValidQ  <= outValidD;
      skidValidQ <= skidValidD;
      inReadyQ   <= !skidValidD;
      outQ       <= outD;
      skidQ      <= skidD;
    end
  end

  assign in_ready  = inReadyQ;
  assign out_valid = outValidQ;
  assign out_imm   = outQ.imm;
  assign out_err   = outQ.err;
  assign out_tag   = outQ.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances on shared inputs,
// checked against a queue model of held entries.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [2:0]  in_immsrc = '0;
  logic [4:0]  in_tag = '0;

  logic        rdy32, vld32, err32;
  logic [31:0] imm32;
  logic [4:0]  tag32;
  logic        rdy64, vld64, err64;
  logic [63:0] imm64;
  logic [4:0]  tag64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
    .out_valid(vld32), .out_ready(out_ready),
    .out_imm(imm32), .out_err(err32), .out_tag(tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_immsrc(in_immsrc), .in_tag(in_tag),
    .out_valid(vld64), .out_ready(out_ready),
    .out_imm(imm64), .out_err(err64), .out_tag(tag64)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint unsigned imm;
    bit              err;
    bit [4:0]        tag;
  } exp_t;

  exp_t q[$];
  bit   expReady = 1'b0;
  int   nChecks = 0;
  int   nFails = 0;

  task automatic chk(string name, logic [63:0] obs, logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, obs, exp, $time);
    end
  endtask

  function automatic longint sx(longint v, int bits);
    longint half = longint'(1) << (bits - 1);
    return (v >= half) ? v - (longint'(1) << bits) : v;
  endfunction

  function automatic longint unsigned refImm(bit [31:0] i, bit [2:0] s,
                                             output bit err);
    err = 1'b0;
    case (s)
      3'd0: return sx(longint'(i[31:20]), 12);
      3'd1: return sx(longint'({i[31:25], i[11:7]}), 12);
      3'd2: return sx(longint'({i[31], i[7], i[30:25], i[11:8]}), 12) * 2;
      3'd3: return sx(longint'(i[31:12]), 20) * 4096;
      3'd4: return sx(longint'({i[31], i[19:12], i[20], i[30:21]}), 20) * 2;
      3'd5: return longint'(i[19:15]);
      default: begin
        err = 1'b1;
        return 0;
      end
    endcase
  endfunction

  task automatic checkOut();
    chk("in_ready32", rdy32, expReady);
    chk("in_ready64", rdy64, expReady);
    chk("out_valid32", vld32, q.size() != 0);
    chk("out_valid64", vld64, q.size() != 0);
    if (q.size() != 0) begin
      chk("imm64", imm64, q[0].imm);
      chk("imm32", imm32, q[0].imm & 64'hFFFF_FFFF);
      chk("err64", err64, q[0].err);
      chk("err32", err32, q[0].err);
      chk("tag64", tag64, q[0].tag);
      chk("tag32", tag32, q[0].tag);
    end
  endtask

  // one cycle: check at negedge, drive, advance model, cross posedge
  task automatic step(bit v, bit [31:0] ins, bit [2:0] src,
                      bit [4:0] tg, bit ordy, bit fl);
    bit   inX, outX;
    exp_t e;
    @(negedge clk);
    checkOut();
    in_valid  = v;
    in_instr  = ins;
    in_immsrc = src;
    in_tag    = tg;
    out_ready = ordy;
    flush     = fl;
    inX  = v && expReady;
    outX = (q.size() != 0) && ordy;
    if (fl) begin
      q.delete();
      expReady = 1'b1;
    end else begin
      if (outX) void'(q.pop_front());
      if (inX) begin
        e.imm = refImm(ins, src, e.err);
        e.tag = tg;
        q.push_back(e);
      end
      expReady = (q.size() < 2);
    end
    @(posedge clk);
  endtask

  initial begin
    #3;
    chk("rst_vld32", vld32, 0);
    chk("rst_rdy32", rdy32, 0);
    chk("rst_imm64", imm64, 0);
    chk("rst_err64", err64, 0);
    chk("rst_tag64", tag64, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    expReady = 1'b1;

    // I and B at XLEN=32, one cycle after accept
    step(1, 32'hFFF00093, 3'b000, 5'd3, 1, 0);
    #1 chk("I_imm32", imm32, 32'hFFFF_FFFF);
    step(1, 32'hFE000EE3, 3'b010, 5'd4, 1, 0);
    #1 chk("B_imm32", imm32, 32'hFFFF_FFFC);

    // U and Z at XLEN=64, back to back
    step(1, 32'h123450B7, 3'b011, 5'd5, 1, 0);
    #1 chk("U_imm64a", imm64, 64'h0000_0000_1234_5000);
    step(1, 32'h80000037, 3'b011, 5'd6, 1, 0);
    #1 chk("U_imm64b", imm64, 64'hFFFF_FFFF_8000_0000);
    step(1, 32'h000FD073, 3'b101, 5'd7, 1, 0);
    #1 chk("Z_imm64", imm64, 64'h0000_0000_0000_001F);

    // illegal code
    step(1, 32'hDEADBEEF, 3'b110, 5'd9, 1, 0);
    #1 chk("ill_imm64", imm64, 0);
    chk("ill_err32", err32, 1);
    chk("ill_tag32", tag32, 5'd9);
    step(0, 0, 0, 0, 1, 0);

    // backpressure
    step(1, 32'h00100093, 3'b000, 5'd1, 0, 0);
    step(1, 32'h00200093, 3'b000, 5'd2, 0, 0);
    #1 chk("bp_rdy", rdy32, 0);
    chk("bp_tag1", tag32, 5'd1);
    step(0, 0, 0, 0, 0, 0);
    #1 chk("bp_hold", tag64, 5'd1);
    step(0, 0, 0, 0, 1, 0);
    #1 chk("bp_tag2", tag32, 5'd2);
    chk("bp_rdy_back", rdy32, 1);
    step(0, 0, 0, 0, 1, 0);
    #1 chk("bp_empty", vld32, 0);

    // flush with both entries full and in_valid high
    step(1, 32'h00500093, 3'b000, 5'd5, 0, 0);
    step(1, 32'h00600093, 3'b000, 5'd6, 0, 0);
    step(1, 32'h00700093, 3'b000, 5'd7, 0, 1);
    #1 chk("fl_vld", vld32, 0);
    chk("fl_rdy", rdy64, 1);
    step(1, 32'h00800093, 3'b000, 5'd8, 1, 1);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);

    // async reset between edges with an entry held
    step(1, 32'h00900093, 3'b000, 5'd10, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld32", vld32, 0);
    chk("arst_vld64", vld64, 0);
    chk("arst_rdy", rdy32, 0);
    chk("arst_imm32", imm32, 0);
    chk("arst_tag64", tag64, 0);
    q.delete();
    expReady = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    expReady = 1'b1;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 9) < 7, $urandom,
           3'($urandom_range(0, 7)), 5'($urandom),
           $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
    end
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    @(negedge clk);
    checkOut();

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
